pic_scan_ctrl: RTL and testbench
================================

Name: pic_scan_ctrl

Overview:
- Frame-scan controller for the picture ROM (`pic_ram`): 9-bit row address and scroll offset in, 240-bit row out.
- Per frame, steps rows 0..ROWS-1 and registers each returned row.
- Serializes each row MSB-first (leftmost pixel first) into BEAT_W-bit beats on a valid/ready stream toward the panel interface driver.
- Vertical scroll value is latched once per frame, so the image does not tear mid-frame.

Parameters:
- ROW_W, 240: pixels (bits) per ROM row. Must be a multiple of BEAT_W.
- ROWS, 320: rows per frame. Must be ≤ 512.
- BEAT_W, 8: pixels per output beat.
- Derived: BEATS = ROW_W/BEAT_W (30). BC_W = $clog2(BEATS).

Ports:
- clk  in  1  system clock; all logic rises on it.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to scan one frame. Ignored while busy.
- scroll_in  in  9  vertical scroll value. Sampled only when start is accepted.
- ram_addr  out  9  row address to pic_ram (registered).
- ram_offset  out  9  scroll offset to pic_ram (registered).
- ram_q  in  ROW_W  row data from pic_ram (combinational from ram_addr/ram_offset).
- px_data  out  BEAT_W  current beat; bit BEAT_W-1 is the leftmost pixel.
- px_valid  out  1  beat valid.
- px_ready  in  1  sink accepts the beat.
- px_sol  out  1  first beat of a row (qualified by px_valid).
- px_eol  out  1  last beat of a row.
- px_eof  out  1  last beat of the frame.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse after the final beat is accepted.

Behaviour:
- Reset: state=IDLE. All of these are 0: ram_addr, ram_offset, px_data, px_valid, px_sol, px_eol, px_eof, busy, frame_done. Internal row and beat counters and the shift buffer are 0.
- Reset has priority over every other input in the same cycle.
- States: IDLE, FETCH, SEND, DONE.
- IDLE:
  - start=1 → latch scroll_in into ram_offset; set row=0, ram_addr=0; go to FETCH.
- FETCH (1 cycle):
  - ram_q is valid combinationally.
  - At the clock edge, row_buf<=ram_q and beat=0; go to SEND.
- SEND:
  - px_valid=1.
  - px_data=row_buf[ROW_W-1 -: BEAT_W].
  - px_sol=(beat==0). px_eol=(beat==BEATS-1). px_eof=px_eol && (row==ROWS-1).
  - Transfer occurs when px_valid && px_ready:
    - If not the last beat: shift row_buf left by BEAT_W; beat++.
    - Last beat, row<ROWS-1: row++, ram_addr<=row+1, go to FETCH.
    - Last beat, row==ROWS-1: go to DONE.
  - px_ready=0: px_data and all flags hold stable. No beat is dropped or duplicated.
- DONE (1 cycle): frame_done=1, px_valid=0, then go to IDLE.
- px_valid is 0 in IDLE, FETCH and DONE.
- Registered-output latency:
  - start is sampled in cycle 0. FETCH of row 0 is in cycle 1. The first beat is valid in cycle 2.
  - Each row costs BEATS cycles plus 1 FETCH cycle at full throughput (31 cycles).
- start while busy: ignored. scroll_in changes mid-frame: no effect until the next accepted start.
- Address arithmetic: ram_addr is the 9-bit row index. Scroll subtraction happens inside pic_ram (address − offset, modulo 512).
- rst mid-frame: the next cycle shows full reset values. The next start begins again at row 0.

Decomposition:
- Package pic_scan_pkg:
  - ROW_W, ROWS and BEAT_W defaults, and BEATS.
  - State enum: IDLE, FETCH, SEND, DONE.
  - Constants ROW_LAST=ROWS-1 and BEAT_LAST=BEATS-1.
- Sub-module pic_row_serializer:
  - Inputs: load, shift, din[ROW_W].
  - Output: dout[BEAT_W] taken from the buffer MSBs.
  - Instantiated once. The FSM and counters stay in pic_scan_ctrl.

Test Plan:
- Bench ROM stub: every byte of q equals (address − offset)[7:0].
1. Reset values: assert rst for 3 cycles → every output is 0; busy=0.
2. Full frame, px_ready=1, scroll_in=0, start at cycle 0:
   - First px_valid at cycle 2.
   - 9600 beats in total, 30 per row.
   - Row r beats = r[7:0].
   - px_sol and px_eol exactly 320 times each; px_eof once, at cycle 9920.
   - frame_done pulses only at cycle 9921; busy is high over cycles 1–9921.
3. Scroll: scroll_in=10 at start → ram_offset=10 for the whole frame. Row 15 beats = 0x05; row 3 beats = 0xF9 (wrap).
4. Backpressure: drop px_ready for 5 cycles at beat 12 of row 7 → px_data=0x07 and all flags stay stable. The beat count per row is still 30 with no duplicates.
5. Ignored inputs: pulse start and change scroll_in to 40 at row 100 → scan continues unchanged and frame_done pulses once. A following start uses offset 40.
6. Reset mid-frame: rst at row 50, beat 3 → outputs reach reset values on the next cycle. A new start restarts with ram_addr=0 and a first beat of 0x00.

Source files
------------

// File: rtl/pic_scan_pkg.sv
// Shared constants and state encoding for the picture ROM frame scanner.
package pic_scan_pkg;

  localparam int ROW_W  = 240;
  localparam int ROWS   = 320;
  localparam int BEAT_W = 8;
  localparam int BEATS  = ROW_W / BEAT_W;
  localparam int BC_W   = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam int ROW_LAST  = ROWS - 1;
  localparam int BEAT_LAST = BEATS - 1;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SEND,
    DONE
  } scan_state_t;

endpackage

// File: rtl/pic_row_serializer.sv
// Holds one ROM row and presents it MSB-first, BEAT_W pixels at a time.
module pic_row_serializer #(
  parameter int ROW_W  = pic_scan_pkg::ROW_W,
  parameter int BEAT_W = pic_scan_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [ROW_W-1:0]  din,
  output logic [BEAT_W-1:0] dout
);
  import pic_scan_pkg::*;

  logic [ROW_W-1:0] row_buf;

  // Load a fresh row, or move the next beat up into the MSBs once the current one is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      row_buf <= '0;
    end else if (load) begin
      row_buf <= din;
    end else if (shift) begin
      row_buf <= {row_buf[ROW_W-BEAT_W-1:0], {BEAT_W{1'b0}}};
    end
  end

  assign dout = row_buf[ROW_W-1 -: BEAT_W];

endmodule

// File: rtl/pic_scan_ctrl.sv
// Frame-scan controller: walks the picture ROM row by row with a per-frame
// latched scroll offset and streams each row out as valid/ready beats.
module pic_scan_ctrl #(
  parameter int ROW_W  = pic_scan_pkg::ROW_W,
  parameter int ROWS   = pic_scan_pkg::ROWS,
  parameter int BEAT_W = pic_scan_pkg::BEAT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [8:0]        scroll_in,
  output logic [8:0]        ram_addr,
  output logic [8:0]        ram_offset,
  input  logic [ROW_W-1:0]  ram_q,
  output logic [BEAT_W-1:0] px_data,
  output logic              px_valid,
  input  logic              px_ready,
  output logic              px_sol,
  output logic              px_eol,
  output logic              px_eof,
  output logic              busy,
  output logic              frame_done
);
  import pic_scan_pkg::*;

  localparam int BEATS = ROW_W / BEAT_W;
  localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BC_W-1:0] BEAT_LAST = BC_W'(BEATS - 1);
  localparam logic [8:0]      ROW_LAST  = 9'(ROWS - 1);

  scan_state_t     state;
  logic [8:0]      row;
  logic [BC_W-1:0] beat;
  logic [BC_W-1:0] beat_next;
  logic            beat_next_last;
  logic            row_is_last;
  logic            buf_load;
  logic            buf_shift;

  // Next-beat decode shared by the flag updates so eol/eof line up with the beat they mark.
  always_comb begin
    beat_next      = beat + 1'b1;
    beat_next_last = (beat_next == BEAT_LAST);
    row_is_last    = (row == ROW_LAST);
  end

  // The row buffer fills during FETCH and only advances when a non-final beat is accepted.
  assign buf_load  = (state == FETCH);
  assign buf_shift = (state == SEND) && px_ready && (beat != BEAT_LAST);

  pic_row_serializer #(
    .ROW_W  (ROW_W),
    .BEAT_W (BEAT_W)
  ) u_ser (
    .clk   (clk),
    .rst   (rst),
    .load  (buf_load),
    .shift (buf_shift),
    .din   (ram_q),
    .dout  (px_data)
  );

  // Scan FSM: counters, ROM address/offset and all stream flags are registered here together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      row        <= '0;
      beat       <= '0;
      ram_addr   <= '0;
      ram_offset <= '0;
      px_valid   <= 1'b0;
      px_sol     <= 1'b0;
      px_eol     <= 1'b0;
      px_eof     <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            ram_offset <= scroll_in;
            row        <= '0;
            ram_addr   <= '0;
            busy       <= 1'b1;
            state      <= FETCH;
          end
        end

        FETCH: begin
          beat     <= '0;
          px_valid <= 1'b1;
          px_sol   <= 1'b1;
          px_eol   <= (BEAT_LAST == '0);
          px_eof   <= (BEAT_LAST == '0) && row_is_last;
          state    <= SEND;
        end

        SEND: begin
          if (px_ready) begin
            if (beat != BEAT_LAST) begin
              beat   <= beat_next;
              px_sol <= 1'b0;
              px_eol <= beat_next_last;
              px_eof <= beat_next_last && row_is_last;
            end else begin
              px_valid <= 1'b0;
              px_sol   <= 1'b0;
              px_eol   <= 1'b0;
              px_eof   <= 1'b0;
              if (!row_is_last) begin
                row      <= row + 9'd1;
                ram_addr <= row + 9'd1;
                state    <= FETCH;
              end else begin
                frame_done <= 1'b1;
                state      <= DONE;
              end
            end
          end
        end

        DONE: begin
          frame_done <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pic_scan_ctrl.sv
// Directed bench for pic_scan_ctrl with a ROM stub whose every byte is (addr - offset)[7:0].
module tb_pic_scan_ctrl;

  logic         clk;
  logic         rst;
  logic         start;
  logic [8:0]   scroll_in;
  logic [8:0]   ram_addr;
  logic [8:0]   ram_offset;
  logic [239:0] ram_q;
  logic [7:0]   px_data;
  logic         px_valid;
  logic         px_ready;
  logic         px_sol;
  logic         px_eol;
  logic         px_eof;
  logic         busy;
  logic         frame_done;

  logic [8:0]   rom_row;

  int checks;
  int errors;

  int first_valid_cyc, beat_total, sol_total, eol_total, eof_total, eof_cyc;
  int done_total, done_cyc, busy_cycles, data_err, flag_err, addr_err, off_err, stall_cycles;
  int row_idx, b_in_row;
  logic [7:0] row15_byte, row3_byte, stall_byte, first_byte;
  logic [8:0] first_addr;
  logic       busy_after, done_after, hit_reset, finished;

  pic_scan_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .scroll_in  (scroll_in),
    .ram_addr   (ram_addr),
    .ram_offset (ram_offset),
    .ram_q      (ram_q),
    .px_data    (px_data),
    .px_valid   (px_valid),
    .px_ready   (px_ready),
    .px_sol     (px_sol),
    .px_eol     (px_eol),
    .px_eof     (px_eof),
    .busy       (busy),
    .frame_done (frame_done)
  );

  // ROM stub: every byte of the row carries the scrolled row index.
  assign rom_row = ram_addr - ram_offset;
  assign ram_q   = {30{rom_row[7:0]}};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one frame from a start pulse, optionally stalling, injecting start/scroll, or resetting mid-frame.
  task automatic applyStimulus(input logic [8:0] scroll,
                               input int bp_row, input int bp_beat, input int bp_len,
                               input int inj_row, input logic [8:0] inj_scroll,
                               input int rst_row, input int rst_beat);
    logic [7:0] exp;
    logic       post_done;
    logic       injected;
    int         bp_count;
    first_valid_cyc = -1; beat_total = 0; sol_total = 0; eol_total = 0;
    eof_total = 0; eof_cyc = -1; done_total = 0; done_cyc = -1; busy_cycles = 0;
    data_err = 0; flag_err = 0; addr_err = 0; off_err = 0; stall_cycles = 0;
    row_idx = 0; b_in_row = 0; row15_byte = 8'hxx; row3_byte = 8'hxx;
    stall_byte = 8'hxx; first_byte = 8'hxx; first_addr = 9'h1ff;
    busy_after = 1'b1; done_after = 1'b1; hit_reset = 1'b0; finished = 1'b0;
    post_done = 1'b0; injected = 1'b0; bp_count = 0;

    @(negedge clk);
    start     = 1'b1;
    scroll_in = scroll;
    px_ready  = 1'b1;

    for (int c = 1; c <= 12000 && !finished; c++) begin
      @(negedge clk);
      start    = 1'b0;
      px_ready = 1'b1;
      if (hit_reset) begin
        finished = 1'b1;
      end else if (post_done) begin
        busy_after = busy;
        done_after = frame_done;
        finished   = 1'b1;
      end else begin
        if (c == 1) first_addr = ram_addr;
        if (ram_offset != scroll) off_err++;
        if (busy) busy_cycles++;
        if (frame_done) begin
          done_total++;
          done_cyc  = c;
          post_done = 1'b1;
        end
        if (px_valid) begin
          exp = 8'(9'(row_idx) - scroll);
          if (first_valid_cyc < 0) begin
            first_valid_cyc = c;
            first_byte      = px_data;
          end
          if (px_data != exp) data_err++;
          if (px_sol != (b_in_row == 0) || px_eol != (b_in_row == 29) ||
              px_eof != (b_in_row == 29 && row_idx == 319)) flag_err++;
          if (ram_addr != 9'(row_idx)) addr_err++;
          if (rst_row == row_idx && rst_beat == b_in_row) begin
            rst       = 1'b1;
            hit_reset = 1'b1;
          end else if (bp_row == row_idx && bp_beat == b_in_row && bp_count < bp_len) begin
            px_ready = 1'b0;
            bp_count++;
            stall_cycles++;
            stall_byte = px_data;
          end else begin
            beat_total++;
            if (px_sol) sol_total++;
            if (px_eol) eol_total++;
            if (px_eof) begin
              eof_total++;
              eof_cyc = c;
            end
            if (row_idx == 15 && b_in_row == 0) row15_byte = px_data;
            if (row_idx == 3 && b_in_row == 0) row3_byte = px_data;
            if (b_in_row == 29) begin
              b_in_row = 0;
              row_idx++;
            end else begin
              b_in_row++;
            end
          end
          if (!injected && row_idx == inj_row) begin
            start     = 1'b1;
            scroll_in = inj_scroll;
            injected  = 1'b1;
          end
        end
      end
    end
    checkOutput("frame_timeout", {31'd0, finished}, 32'd1);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    start     = 1'b0;
    scroll_in = 9'd0;
    px_ready  = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("reset_outs", {ram_addr, ram_offset, px_data, px_valid, px_sol,
                               px_eol, px_eof, busy, frame_done}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    // Full frame at full throughput, no scroll
    $display("[TB] full frame, scroll 0");
    applyStimulus(9'd0, -1, -1, 0, -1, 9'd0, -1, -1);
    checkOutput("f_first_valid", first_valid_cyc, 2);
    checkOutput("f_first_addr", first_addr, 0);
    checkOutput("f_beats", beat_total, 9600);
    checkOutput("f_rows", row_idx, 320);
    checkOutput("f_sol", sol_total, 320);
    checkOutput("f_eol", eol_total, 320);
    checkOutput("f_eof_count", eof_total, 1);
    checkOutput("f_eof_cyc", eof_cyc, 9920);
    checkOutput("f_done_count", done_total, 1);
    checkOutput("f_done_cyc", done_cyc, 9921);
    checkOutput("f_busy_cycles", busy_cycles, 9921);
    checkOutput("f_busy_after", {31'd0, busy_after}, 0);
    checkOutput("f_done_after", {31'd0, done_after}, 0);
    checkOutput("f_data_err", data_err, 0);
    checkOutput("f_flag_err", flag_err, 0);
    checkOutput("f_addr_err", addr_err, 0);
    checkOutput("f_off_err", off_err, 0);

    // Scroll by 10, including wrap below row 0
    $display("[TB] full frame, scroll 10");
    applyStimulus(9'd10, -1, -1, 0, -1, 9'd0, -1, -1);
    checkOutput("s_off_err", off_err, 0);
    checkOutput("s_row15", row15_byte, 8'h05);
    checkOutput("s_row3", row3_byte, 8'hF9);
    checkOutput("s_data_err", data_err, 0);
    checkOutput("s_beats", beat_total, 9600);

    // Backpressure at row 7 beat 12, plus start/scroll change at row 100
    $display("[TB] backpressure and ignored start");
    applyStimulus(9'd0, 7, 12, 5, 100, 9'd40, -1, -1);
    checkOutput("b_stall_cycles", stall_cycles, 5);
    checkOutput("b_stall_byte", stall_byte, 8'h07);
    checkOutput("b_flag_err", flag_err, 0);
    checkOutput("b_data_err", data_err, 0);
    checkOutput("b_beats", beat_total, 9600);
    checkOutput("b_off_err", off_err, 0);
    checkOutput("b_done_count", done_total, 1);
    checkOutput("b_done_after", {31'd0, done_after}, 0);

    // Next start picks up the new scroll of 40
    $display("[TB] full frame, scroll 40");
    applyStimulus(9'd40, -1, -1, 0, -1, 9'd0, -1, -1);
    checkOutput("n_off_err", off_err, 0);
    checkOutput("n_first_byte", first_byte, 8'hD8);
    checkOutput("n_data_err", data_err, 0);

    // Reset in the middle of row 50
    $display("[TB] mid-frame reset");
    applyStimulus(9'd0, -1, -1, 0, -1, 9'd0, 50, 3);
    checkOutput("r_hit", {31'd0, hit_reset}, 1);
    checkOutput("r_outs", {ram_addr, ram_offset, px_data, px_valid, px_sol,
                           px_eol, px_eof, busy, frame_done}, 32'd0);
    rst = 1'b0;
    applyStimulus(9'd0, -1, -1, 0, -1, 9'd0, -1, -1);
    checkOutput("r_first_addr", first_addr, 0);
    checkOutput("r_first_valid", first_valid_cyc, 2);
    checkOutput("r_first_byte", first_byte, 8'h00);
    checkOutput("r_beats", beat_total, 9600);
    checkOutput("r_data_err", data_err, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
